// File: rtl/led_ctrl_multi_if.sv
// Configuration port of the multi-channel LED driver: valid/ready write channel
// with a one-cycle error pulse for writes to a channel that does not exist.
interface led_ctrl_multi_if #(
  parameter int N_CH     = 4,
  parameter int PWM_BITS = 8
);
  localparam int CH_W = $clog2(N_CH) + 1;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [1:0]          cfg_mode;
  logic [PWM_BITS-1:0] cfg_duty;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_duty,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_duty,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/led_ctrl_multi.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM modes driven by a shared,
// free-running prescaler, PWM counter and blink phase.
module led_ctrl_multi #(
  parameter int N_CH        = 4,
  parameter int PRESCALE    = 1000,
  parameter int PWM_BITS    = 8,
  parameter int BLINK_TICKS = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  led_ctrl_multi_if.slave  cfg,
  output logic [N_CH-1:0]  led
);
  localparam int CH_W  = $clog2(N_CH) + 1;
  localparam int PRE_W = $clog2(PRESCALE);
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_TICKS - 1);
  localparam logic [CH_W-1:0]  CH_LIMIT  = CH_W'(N_CH);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PWM   = 2'd3;

  logic [1:0]          mode_q [N_CH];
  logic [PWM_BITS-1:0] duty_q [N_CH];
  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BLK_W-1:0]    blk_cnt;
  logic                blk_phase;
  logic                ready_q;
  logic                err_q;
  logic                tick;
  logic                accept;

  function automatic logic led_bit(
    input logic [1:0]          mode,
    input logic [PWM_BITS-1:0] duty,
    input logic [PWM_BITS-1:0] pwm,
    input logic                phase
  );
    logic bit_v;
    case (mode)
      MODE_OFF:   bit_v = 1'b0;
      MODE_ON:    bit_v = 1'b1;
      MODE_BLINK: bit_v = phase;
      default:    bit_v = (pwm < duty);
    endcase
    return bit_v;
  endfunction

  always_comb begin
    tick   = (pre_cnt == PRE_LAST);
    accept = cfg.cfg_valid && ready_q;
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      pre_cnt   <= '0;
      pwm_cnt   <= '0;
      blk_cnt   <= '0;
      blk_phase <= 1'b0;
      led       <= '0;
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i] <= MODE_OFF;
        duty_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      err_q   <= accept && (cfg.cfg_ch >= CH_LIMIT);
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
        if (blk_cnt == BLK_LAST) begin
          blk_cnt   <= '0;
          blk_phase <= ~blk_phase;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end
      // LED uses the pre-edge mode, so a write shows up one edge after it is accepted
      for (int i = 0; i < N_CH; i++) begin
        led[i] <= led_bit(mode_q[i], duty_q[i], pwm_cnt, blk_phase);
        if (accept && (cfg.cfg_ch == CH_W'(i))) begin
          mode_q[i] <= cfg.cfg_mode;
          duty_q[i] <= cfg.cfg_duty;
        end
      end
    end
  end
endmodule

// File: tb/tb_led_ctrl_multi.sv
// Bench for led_ctrl_multi: directed tables, multi-cycle corner sequences and a
// randomized run, all checked every cycle against a cycle-count based model.
module tb_led_ctrl_multi;
  localparam int N_CH        = 4;
  localparam int PRESCALE    = 4;
  localparam int PWM_BITS    = 3;
  localparam int BLINK_TICKS = 2;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] led;

  led_ctrl_multi_if #(.N_CH(N_CH), .PWM_BITS(PWM_BITS)) cif ();

  led_ctrl_multi #(
    .N_CH(N_CH), .PRESCALE(PRESCALE), .PWM_BITS(PWM_BITS), .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cif.slave), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outputs derived from the number of edges since reset release
  int                  cyc;
  logic [1:0]          m_mode [N_CH];
  logic [PWM_BITS-1:0] m_duty [N_CH];
  logic [N_CH-1:0]     exp_led;
  logic                exp_err;
  logic                exp_ready;

  typedef struct {
    logic [2:0] ch;
    logic [1:0] mode;
    logic [2:0] duty;
    logic [3:0] exp_led;
    logic       exp_err;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_edge();
    int ticks, pwm, phase;
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_mode[i] = 2'd0;
        m_duty[i] = '0;
      end
      exp_led = '0; exp_err = 1'b0; exp_ready = 1'b0;
    end else begin
      ticks = cyc / PRESCALE;
      pwm   = ticks % (1 << PWM_BITS);
      phase = (ticks / BLINK_TICKS) % 2;
      for (int i = 0; i < N_CH; i++) begin
        case (m_mode[i])
          2'd0: exp_led[i] = 1'b0;
          2'd1: exp_led[i] = 1'b1;
          2'd2: exp_led[i] = (phase == 1);
          default: exp_led[i] = (pwm < int'(m_duty[i]));
        endcase
      end
      exp_err = 1'b0;
      if (cif.cfg_valid && cyc >= 1) begin
        if (int'(cif.cfg_ch) < N_CH) begin
          m_mode[cif.cfg_ch[1:0]] = cif.cfg_mode;
          m_duty[cif.cfg_ch[1:0]] = cif.cfg_duty;
        end else begin
          exp_err = 1'b1;
        end
      end
      exp_ready = 1'b1;
      cyc++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("led", 32'(led), 32'(exp_led));
    check("cfg_ready", 32'(cif.cfg_ready), 32'(exp_ready));
    check("cfg_err", 32'(cif.cfg_err), 32'(exp_err));
  endtask

  task automatic write(input logic [2:0] ch, input logic [1:0] mode, input logic [2:0] duty);
    cif.cfg_valid = 1'b1;
    cif.cfg_ch    = ch;
    cif.cfg_mode  = mode;
    cif.cfg_duty  = duty;
    step();
    cif.cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic count_high(input int bitn, input int cycles, output int highs, output int edges);
    logic prev;
    highs = 0;
    edges = 0;
    prev  = led[bitn];
    for (int k = 0; k < cycles; k++) begin
      step();
      if (led[bitn]) highs++;
      if (led[bitn] != prev) edges++;
      prev = led[bitn];
    end
  endtask

  int highs, edges, err_pulses;

  initial begin
    rst_n = 1'b0;
    cif.cfg_valid = 1'b0;
    cif.cfg_ch = '0;
    cif.cfg_mode = '0;
    cif.cfg_duty = '0;

    // Reset held with a pending write
    cif.cfg_valid = 1'b1; cif.cfg_ch = 3'd2; cif.cfg_mode = 2'd1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("rst_led", 32'(led), 32'h0);
      check("rst_ready", 32'(cif.cfg_ready), 32'h0);
    end
    cif.cfg_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check("ready_after_release", 32'(cif.cfg_ready), 32'h1);
    step();

    // Directed table of mode writes with counter-independent results
    tbl[0] = '{3'd2, 2'd1, 3'd0, 4'b0100, 1'b0};
    tbl[1] = '{3'd2, 2'd0, 3'd0, 4'b0000, 1'b0};
    tbl[2] = '{3'd0, 2'd1, 3'd0, 4'b0001, 1'b0};
    tbl[3] = '{3'd3, 2'd1, 3'd5, 4'b1001, 1'b0};
    tbl[4] = '{3'd6, 2'd0, 3'd0, 4'b1001, 1'b1};
    tbl[5] = '{3'd0, 2'd0, 3'd0, 4'b1000, 1'b0};
    tbl[6] = '{3'd1, 2'd3, 3'd0, 4'b1000, 1'b0};
    tbl[7] = '{3'd3, 2'd0, 3'd0, 4'b0000, 1'b0};
    for (int v = 0; v < 8; v++) begin
      write(tbl[v].ch, tbl[v].mode, tbl[v].duty);
      check($sformatf("tbl%0d_err", v), 32'(cif.cfg_err), 32'(tbl[v].exp_err));
      step();
      check($sformatf("tbl%0d_led", v), 32'(led), 32'(tbl[v].exp_led));
    end

    // Blink: starts dark after reset, toggles every 8 clocks
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    write(3'd0, 2'd2, 3'd0);
    step();
    check("blink_start", 32'(led[0]), 32'h0);
    count_high(0, 32, highs, edges);
    check("blink_highs", 32'(highs), 32'd16);
    check("blink_toggles", 32'(edges), 32'd4);

    // PWM duty sweep on ch1
    do_reset();
    write(3'd1, 2'd3, 3'd3);
    count_high(1, 32, highs, edges);
    check("pwm_duty3", 32'(highs), 32'd12);
    write(3'd1, 2'd3, 3'd0);
    count_high(1, 32, highs, edges);
    check("pwm_duty0", 32'(highs), 32'd0);
    write(3'd1, 2'd3, 3'd7);
    count_high(1, 32, highs, edges);
    check("pwm_duty7", 32'(highs), 32'd28);

    // Out-of-range write followed back-to-back by a valid one
    do_reset();
    err_pulses = 0;
    cif.cfg_valid = 1'b1; cif.cfg_ch = 3'd5; cif.cfg_mode = 2'd1; cif.cfg_duty = 3'd0;
    step();
    if (cif.cfg_err) err_pulses++;
    cif.cfg_ch = 3'd3;
    step();
    if (cif.cfg_err) err_pulses++;
    cif.cfg_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (cif.cfg_err) err_pulses++;
    end
    check("err_pulses", 32'(err_pulses), 32'd1);
    check("b2b_led", 32'(led), 32'b1000);

    // Reset in the middle of PWM/BLINK activity
    write(3'd1, 2'd3, 3'd7);
    write(3'd0, 2'd2, 3'd0);
    repeat (21) step();
    rst_n = 1'b0;
    step();
    check("midrst_led", 32'(led), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) step();
    check("midrst_all_off", 32'(led), 32'h0);

    // Randomized traffic including occasional resets
    for (int k = 0; k < 600; k++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      cif.cfg_valid = ($urandom_range(0, 2) == 0);
      cif.cfg_ch    = 3'($urandom_range(0, 7));
      cif.cfg_mode  = 2'($urandom_range(0, 3));
      cif.cfg_duty  = 3'($urandom_range(0, 7));
      step();
    end
    cif.cfg_valid = 1'b0;
    rst_n = 1'b1;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
